// File: rtl/instr_mem_loader.sv
// instr_mem_loader: writable instruction store for the sCPU.
// A byte stream arriving over a valid/ready handshake is written sequentially
// into a DEPTH x DATA_W register array. The fetch path reads the same array
// combinationally through sel -> instruction. The CPU is held in reset while
// a load is in progress.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   When defined, one extra checksum byte follows the DEPTH program bytes.
//   A bad checksum flags err and keeps cpu_hold asserted until the next
//   start or reset, so a corrupt program never runs.
//   When undefined, there is no CHECK state and no running sum, and err is
//   tied low.
module instr_mem_loader #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] sel,
    output logic [DATA_W-1:0] instruction,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] wr_addr
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [1:0] S_CHECK = 2'd2;
`endif
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [1:0]        state;
    logic              loading;
    logic              last_word;

    assign last_word = (wr_addr == ADDR_W'(DEPTH - 1));

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum;
    logic [7:0] check_total;
    logic       err_q;

    assign check_total = sum + 8'(in_data);
    assign loading     = (state == S_LOAD) || (state == S_CHECK);
    assign err         = err_q;

    // Load sequencer with running checksum and memory write port
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            wr_addr <= '0;
            done    <= 1'b0;
            err_q   <= 1'b0;
            sum     <= 8'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state   <= S_LOAD;
                        wr_addr <= '0;
                        done    <= 1'b0;
                        err_q   <= 1'b0;
                        sum     <= 8'd0;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (in_valid) begin
                        mem[wr_addr] <= in_data;
                        wr_addr      <= wr_addr + ADDR_W'(1);
                        sum          <= sum + 8'(in_data);
                        if (last_word) begin
                            state <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (in_valid) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        err_q <= (check_total != 8'd0);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
`else
    assign loading = (state == S_LOAD);
    assign err     = 1'b0;

    // Load sequencer and memory write port
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            wr_addr <= '0;
            done    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state   <= S_LOAD;
                        wr_addr <= '0;
                        done    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (in_valid) begin
                        mem[wr_addr] <= in_data;
                        wr_addr      <= wr_addr + ADDR_W'(1);
                        if (last_word) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
`endif

    // Handshake, hold and fetch outputs; no bypass from in_data to instruction
    always_comb begin
        in_ready    = loading;
        busy        = loading;
        cpu_hold    = loading || err;
        instruction = mem[sel];
    end

endmodule
